// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

    // Round-robin successor of a producer index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan every offset from rr_ptr and keep the first hit.
    always_comb begin
        logic [IDX_W-1:0] w_pos;
        found = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one fifo write port between N_REQ producers.
// Optional statistics counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int N_REQ      = 4,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_last,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH-1:0]       fifo_data,
    output logic                        gnt_valid,
`ifdef FIFO_ARB_STATS_EN
    output logic [N_REQ*STAT_W-1:0]     stat_beats,
    output logic [STAT_W-1:0]           stat_stall,
`endif
    output logic [IDX_W-1:0]            gnt_idx
);

    arb_state_e             r_state;
    logic [IDX_W-1:0]       r_gnt_idx;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic                   w_found;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_acc;
    logic                   w_stall;
    logic [DATA_WIDTH-1:0]  w_slices [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign w_slices[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_pick_idx)
    );

    assign gnt_valid = (r_state == ST_LOCK);
    assign gnt_idx   = r_gnt_idx;

    // Beat handshake toward the locked producer and the fifo write port.
    always_comb begin
        w_acc      = 1'b0;
        w_stall    = 1'b0;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        if (r_state == ST_LOCK) begin
            w_acc                = req_valid[r_gnt_idx] & ~fifo_full;
            w_stall              = req_valid[r_gnt_idx] & fifo_full;
            req_ready[r_gnt_idx] = w_acc;
            fifo_wr_en           = w_acc;
            fifo_data            = w_slices[r_gnt_idx];
        end else begin
            fifo_data = '0;
        end
    end

    // Arbitration FSM: one cycle to pick in IDLE, hold the lock until the last beat lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt_idx <= w_pick_idx;
                        r_state   <= ST_LOCK;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (w_acc && req_last[r_gnt_idx]) begin
                        r_rr_ptr <= IDX_W'(rr_next(int'(r_gnt_idx), N_REQ));
                        r_state  <= ST_IDLE;
                    end else begin
                        r_state  <= ST_LOCK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_beats [N_REQ];
    logic [STAT_W-1:0] r_stat_stall;

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_beats[g*STAT_W +: STAT_W] = r_stat_beats[g];
    end
    assign stat_stall = r_stat_stall;

    // Beat counters wrap naturally; the stall counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_stat_beats[i] <= '0;
            end
            r_stat_stall <= '0;
        end else begin
            if (w_acc) begin
                r_stat_beats[r_gnt_idx] <= r_stat_beats[r_gnt_idx] + STAT_W'(1);
            end else begin
                r_stat_beats[r_gnt_idx] <= r_stat_beats[r_gnt_idx];
            end
            if (w_stall && (r_stat_stall != {STAT_W{1'b1}})) begin
                r_stat_stall <= r_stat_stall + STAT_W'(1);
            end else begin
                r_stat_stall <= r_stat_stall;
            end
        end
    end
`endif

endmodule
